// File: rtl/id_ex_if.sv
// Bundle of ID-side, forwarding-source and EX-side signals around the ID/EX pipeline register.
// The stage uses the slave modport; the decode/hazard environment drives through master.
interface id_ex_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [XLEN-1:0]  id_pc;
    logic [3:0]       id_alu_ctrl;
    logic             id_use_imm;
    logic             id_use_pc;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             flush;
    logic             ex_hold;
    logic [4:0]       exmem_rd;
    logic             exmem_reg_write;
    logic [XLEN-1:0]  exmem_result;
    logic [4:0]       memwb_rd;
    logic             memwb_reg_write;
    logic [XLEN-1:0]  memwb_result;

    logic             stall_o;
    logic             ex_valid;
    logic [XLEN-1:0]  alu_in1;
    logic [XLEN-1:0]  alu_in2;
    logic [3:0]       alu_ctrl;
    logic [XLEN-1:0]  store_data;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_ctrl,
               id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write,
               flush, ex_hold,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        input  stall_o, ex_valid, alu_in1, alu_in2, alu_ctrl, store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               fwd_a, fwd_b, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_pc, id_alu_ctrl,
               id_use_imm, id_use_pc, id_reg_write, id_mem_read, id_mem_write,
               flush, ex_hold,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        output stall_o, ex_valid, alu_in1, alu_in2, alu_ctrl, store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               fwd_a, fwd_b, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: operand forwarding, ALU operand muxing,
// load-use hazard detection with bubble injection, and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    id_ex_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             valid_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic [3:0]       alu_ctrl_q;
    logic             use_imm_q;
    logic             use_pc_q;
    logic             reg_write_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [XLEN-1:0]  rs1_data_q;
    logic [XLEN-1:0]  rs2_data_q;
    logic [XLEN-1:0]  imm_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic             load_use;
    logic             load_bubble;
    logic             count_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [XLEN-1:0]  rs1_fwd;
    logic [XLEN-1:0]  rs2_fwd;

    // A load in EX whose destination the ID instruction reads cannot be forwarded in time.
    always_comb begin
        load_use = bus.id_valid && valid_q && mem_read_q && (rd_q != 5'd0) &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == rd_q)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == rd_q)));
        load_bubble  = bus.flush || load_use || !bus.id_valid;
        count_bubble = bus.id_valid && (bus.flush || load_use);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            alu_ctrl_q   <= 4'd0;
            use_imm_q    <= 1'b0;
            use_pc_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            bubble_cnt_q <= '0;
        end else if (!bus.ex_hold) begin
            if (load_bubble) begin
                valid_q     <= 1'b0;
                rs1_q       <= 5'd0;
                rs2_q       <= 5'd0;
                rd_q        <= 5'd0;
                alu_ctrl_q  <= 4'd0;
                use_imm_q   <= 1'b0;
                use_pc_q    <= 1'b0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                rs1_data_q  <= '0;
                rs2_data_q  <= '0;
                imm_q       <= '0;
                pc_q        <= '0;
            end else begin
                valid_q     <= 1'b1;
                rs1_q       <= bus.id_rs1;
                rs2_q       <= bus.id_rs2;
                rd_q        <= bus.id_rd;
                alu_ctrl_q  <= bus.id_alu_ctrl;
                use_imm_q   <= bus.id_use_imm;
                use_pc_q    <= bus.id_use_pc;
                reg_write_q <= bus.id_reg_write;
                mem_read_q  <= bus.id_mem_read;
                mem_write_q <= bus.id_mem_write;
                rs1_data_q  <= bus.id_rs1_data;
                rs2_data_q  <= bus.id_rs2_data;
                imm_q       <= bus.id_imm;
                pc_q        <= bus.id_pc;
            end
            if (count_bubble && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    // The younger producer (EX/MEM) wins; x0 never forwards and an empty stage selects regfile.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (valid_q) begin
            if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs1_q)) begin
                fwd_a = 2'b10;
            end else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs1_q)) begin
                fwd_a = 2'b01;
            end
            if (bus.exmem_reg_write && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == rs2_q)) begin
                fwd_b = 2'b10;
            end else if (bus.memwb_reg_write && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == rs2_q)) begin
                fwd_b = 2'b01;
            end
        end
    end

    always_comb begin
        unique case (fwd_a)
            2'b10:   rs1_fwd = bus.exmem_result;
            2'b01:   rs1_fwd = bus.memwb_result;
            default: rs1_fwd = rs1_data_q;
        endcase
        unique case (fwd_b)
            2'b10:   rs2_fwd = bus.exmem_result;
            2'b01:   rs2_fwd = bus.memwb_result;
            default: rs2_fwd = rs2_data_q;
        endcase
    end

    // Operands are forced to zero on a bubble so the ALU (ctrl 0000) yields zero.
    assign bus.alu_in1    = !valid_q ? '0 : (use_pc_q  ? pc_q  : rs1_fwd);
    assign bus.alu_in2    = !valid_q ? '0 : (use_imm_q ? imm_q : rs2_fwd);
    assign bus.store_data = !valid_q ? '0 : rs2_fwd;

    assign bus.stall_o      = load_use || bus.ex_hold;
    assign bus.ex_valid     = valid_q;
    assign bus.alu_ctrl     = alu_ctrl_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_reg_write = reg_write_q;
    assign bus.ex_mem_read  = mem_read_q;
    assign bus.ex_mem_write = mem_write_q;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;
    assign bus.bubble_cnt   = bubble_cnt_q;
endmodule
